// File: rtl/acq_seq_pkg.sv
// Shared types for the acquisition sequencer: state encoding, default widths
// and the small decode helpers used by the top level.
package acq_seq_pkg;

   localparam int CNT_W_DEF = 16;
   localparam int RX_W_DEF  = 32;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ARMED = 3'd1,
      S_TX    = 3'd2,
      S_DELAY = 3'd3,
      S_RX    = 3'd4,
      S_GAP   = 3'd5,
      S_DONE  = 3'd6
   } acq_state_e;

   // Debug pins carry the raw state code so a scope trace reads directly.
   function automatic logic [2:0] state_dbg_enc(input acq_state_e s);
      return 3'(s);
   endfunction

   function automatic logic is_busy(input acq_state_e s);
      return (s inside {S_TX, S_DELAY, S_RX, S_GAP, S_DONE});
   endfunction

endpackage

// File: rtl/acq_sequencer_if.sv
// Host-side configuration/trigger bundle and DAC/FIFO control outputs of the
// acquisition sequencer.
interface acq_sequencer_if
   import acq_seq_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF,
   parameter int RX_W  = RX_W_DEF
);
   logic [CNT_W-1:0] cfg_tx_cycles;
   logic [CNT_W-1:0] cfg_rx_delay;
   logic [RX_W-1:0]  cfg_rx_samples;
   logic [CNT_W-1:0] cfg_gap;
   logic [CNT_W-1:0] cfg_shots;
   logic             acq_start;
   logic             acq_abort;
   logic             ready_in;
   logic             fifo_prog_full;

   logic             tx_en;
   logic             fifo_wr_en;
   logic             busy;
   logic             acq_done;
   logic             aborted;
   logic             overflow;
   logic [CNT_W-1:0] shot_idx;
   logic [2:0]       state_dbg;

   modport master (
      output cfg_tx_cycles, cfg_rx_delay, cfg_rx_samples, cfg_gap, cfg_shots,
             acq_start, acq_abort, ready_in, fifo_prog_full,
      input  tx_en, fifo_wr_en, busy, acq_done, aborted, overflow,
             shot_idx, state_dbg
   );

   modport slave (
      input  cfg_tx_cycles, cfg_rx_delay, cfg_rx_samples, cfg_gap, cfg_shots,
             acq_start, acq_abort, ready_in, fifo_prog_full,
      output tx_en, fifo_wr_en, busy, acq_done, aborted, overflow,
             shot_idx, state_dbg
   );
endinterface

// File: rtl/acq_sequencer_phase_counter.sv
// Loadable down-counter; terminal flag is high while the count sits at zero.
// Loading length-1 on phase entry makes the phase last exactly 'length' clocks.
module acq_phase_counter #(
   parameter int W = 16
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         load_i,
   input  logic [W-1:0] load_val_i,
   output logic         term_o
);
   logic [W-1:0] cnt_q;

   always_ff @(posedge clk_i) begin
      if (rst_i)               cnt_q <= '0;
      else if (load_i)         cnt_q <= load_val_i;
      else if (cnt_q != '0)    cnt_q <= cnt_q - W'(1);
   end

   assign term_o = (cnt_q == '0);
endmodule

// File: rtl/acq_sequencer.sv
// Triggered multi-shot acquisition sequencer: TX window, TX-to-RX delay, exact
// length FIFO write window and inter-shot gap, repeated for the latched shot count.
module acq_sequencer
   import acq_seq_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF,
   parameter int RX_W  = RX_W_DEF
) (
   input  logic            adc_data_clk,
   input  logic            reset,
   acq_sequencer_if.slave  bus
);
   acq_state_e       state_q, state_d;

   logic [CNT_W-1:0] tx_m1_q, delay_q, gap_q, last_shot_q, shot_idx_q;
   logic [RX_W-1:0]  samples_q;
   logic             tx_en_q, wr_en_q, busy_q, done_q, aborted_q, ovf_q;
   logic [2:0]       dbg_q;

   logic             ph_load, rx_load, ph_term, rx_term;
   logic [CNT_W-1:0] ph_val;
   logic [RX_W-1:0]  rx_val;
   logic             shot_inc, start_acc, abort_acc;

   acq_state_e       post_rx_s;
   logic             post_rx_load, post_rx_inc;
   logic [CNT_W-1:0] post_rx_val;

   function automatic logic [CNT_W-1:0] len_m1(input logic [CNT_W-1:0] v);
      return (v == '0) ? '0 : v - CNT_W'(1);
   endfunction

   acq_phase_counter #(.W(CNT_W)) u_ph_cnt (
      .clk_i      (adc_data_clk),
      .rst_i      (reset),
      .load_i     (ph_load),
      .load_val_i (ph_val),
      .term_o     (ph_term)
   );

   acq_phase_counter #(.W(RX_W)) u_rx_cnt (
      .clk_i      (adc_data_clk),
      .rst_i      (reset),
      .load_i     (rx_load),
      .load_val_i (rx_val),
      .term_o     (rx_term)
   );

   // Successor of the RX window; also used when RX is skipped entirely.
   always_comb begin
      post_rx_s    = S_DONE;
      post_rx_load = 1'b0;
      post_rx_inc  = 1'b0;
      post_rx_val  = tx_m1_q;
      if (gap_q != '0) begin
         post_rx_s    = S_GAP;
         post_rx_load = 1'b1;
         post_rx_val  = gap_q - CNT_W'(1);
      end else if (shot_idx_q != last_shot_q) begin
         post_rx_s    = S_TX;
         post_rx_load = 1'b1;
         post_rx_inc  = 1'b1;
      end
   end

   always_comb begin
      state_d   = state_q;
      ph_load   = 1'b0;
      ph_val    = '0;
      rx_load   = 1'b0;
      rx_val    = '0;
      shot_inc  = 1'b0;
      start_acc = 1'b0;
      abort_acc = 1'b0;
      case (state_q)
         S_IDLE:
            if (bus.ready_in && !bus.fifo_prog_full) state_d = S_ARMED;
         S_ARMED:
            if (!bus.ready_in) state_d = S_IDLE;
            else if (bus.acq_start && !bus.acq_abort) begin
               start_acc = 1'b1;
               state_d   = S_TX;
               ph_load   = 1'b1;
               ph_val    = len_m1(bus.cfg_tx_cycles);
            end
         S_TX:
            if (ph_term) begin
               if (delay_q != '0) begin
                  state_d = S_DELAY;
                  ph_load = 1'b1;
                  ph_val  = delay_q - CNT_W'(1);
               end else if (samples_q != '0) begin
                  state_d = S_RX;
                  rx_load = 1'b1;
                  rx_val  = samples_q - RX_W'(1);
               end else begin
                  state_d  = post_rx_s;
                  ph_load  = post_rx_load;
                  ph_val   = post_rx_val;
                  shot_inc = post_rx_inc;
               end
            end
         S_DELAY:
            if (ph_term) begin
               if (samples_q != '0) begin
                  state_d = S_RX;
                  rx_load = 1'b1;
                  rx_val  = samples_q - RX_W'(1);
               end else begin
                  state_d  = post_rx_s;
                  ph_load  = post_rx_load;
                  ph_val   = post_rx_val;
                  shot_inc = post_rx_inc;
               end
            end
         S_RX:
            if (rx_term) begin
               state_d  = post_rx_s;
               ph_load  = post_rx_load;
               ph_val   = post_rx_val;
               shot_inc = post_rx_inc;
            end
         S_GAP:
            if (ph_term) begin
               if (shot_idx_q == last_shot_q) state_d = S_DONE;
               else begin
                  state_d  = S_TX;
                  ph_load  = 1'b1;
                  ph_val   = tx_m1_q;
                  shot_inc = 1'b1;
               end
            end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      if (bus.acq_abort && is_busy(state_q)) begin
         state_d   = S_IDLE;
         abort_acc = 1'b1;
         ph_load   = 1'b0;
         rx_load   = 1'b0;
         shot_inc  = 1'b0;
      end
   end

   // Outputs are decoded from the next state so each phase output lines up
   // with the cycle the state register enters that phase.
   always_ff @(posedge adc_data_clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         tx_en_q     <= 1'b0;
         wr_en_q     <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         aborted_q   <= 1'b0;
         ovf_q       <= 1'b0;
         dbg_q       <= 3'd0;
         shot_idx_q  <= '0;
         tx_m1_q     <= '0;
         delay_q     <= '0;
         gap_q       <= '0;
         last_shot_q <= '0;
         samples_q   <= '0;
      end else begin
         state_q   <= state_d;
         tx_en_q   <= (state_d == S_TX);
         wr_en_q   <= (state_d == S_RX) && !bus.fifo_prog_full;
         busy_q    <= is_busy(state_d);
         done_q    <= (state_d == S_DONE);
         aborted_q <= abort_acc;
         dbg_q     <= state_dbg_enc(state_d);
         if (start_acc) begin
            tx_m1_q     <= len_m1(bus.cfg_tx_cycles);
            delay_q     <= bus.cfg_rx_delay;
            samples_q   <= bus.cfg_rx_samples;
            gap_q       <= bus.cfg_gap;
            last_shot_q <= len_m1(bus.cfg_shots);
            shot_idx_q  <= '0;
            ovf_q       <= 1'b0;
         end else begin
            if (shot_inc) shot_idx_q <= shot_idx_q + CNT_W'(1);
            if ((state_d == S_RX) && bus.fifo_prog_full) ovf_q <= 1'b1;
         end
      end
   end

   assign bus.tx_en      = tx_en_q;
   assign bus.fifo_wr_en = wr_en_q;
   assign bus.busy       = busy_q;
   assign bus.acq_done   = done_q;
   assign bus.aborted    = aborted_q;
   assign bus.overflow   = ovf_q;
   assign bus.shot_idx   = shot_idx_q;
   assign bus.state_dbg  = dbg_q;
endmodule

// File: tb/tb_acq_sequencer.sv
// Directed bench for acq_sequencer: per-cycle traces captured relative to the
// accepted start and compared against hand-derived bit patterns.
module tb_acq_sequencer;
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   acq_sequencer_if #(.CNT_W(16), .RX_W(32)) bus ();

   acq_sequencer #(.CNT_W(16), .RX_W(32)) dut (
      .adc_data_clk (clk),
      .reset        (reset),
      .bus          (bus)
   );

   logic [63:0] tx_bits, wr_bits, done_bits;
   logic [15:0] sh [64];
   int          n_tx, n_wr, n_done, n_abort, end_cyc;

   task automatic set_cfg(input int tx, input int dl, input int rx, input int gap, input int shots);
      bus.cfg_tx_cycles  = 16'(tx);
      bus.cfg_rx_delay   = 16'(dl);
      bus.cfg_rx_samples = 32'(rx);
      bus.cfg_gap        = 16'(gap);
      bus.cfg_shots      = 16'(shots);
   endtask

   task automatic arm();
      int n = 0;
      bus.ready_in = 1'b1;
      bus.fifo_prog_full = 1'b0;
      while (bus.state_dbg !== 3'd1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (bus.state_dbg !== 3'd1) begin
         failures++;
         $display("FAIL arm state_dbg got=%0d exp=1", bus.state_dbg);
      end
   endtask

   // Pulses start in ARMED, then records cycle i = 1.. after the accepted start
   // until busy drops. pf/st masks drive prog_full/start for the following edge.
   task automatic capture(input logic [63:0] pf_mask, input logic [63:0] st_mask,
                          input bit scramble, input int maxc);
      tx_bits = '0; wr_bits = '0; done_bits = '0;
      n_tx = 0; n_wr = 0; n_done = 0; n_abort = 0; end_cyc = -1;
      for (int j = 0; j < 64; j++) sh[j] = 16'hffff;
      bus.acq_start = 1'b1;
      @(negedge clk);
      bus.acq_start = 1'b0;
      if (scramble) set_cfg(7, 3, 1, 0, 9);
      for (int i = 1; i <= maxc; i++) begin
         if (bus.tx_en)      begin n_tx++;   if (i < 64) tx_bits[i] = 1'b1;   end
         if (bus.fifo_wr_en) begin n_wr++;   if (i < 64) wr_bits[i] = 1'b1;   end
         if (bus.acq_done)   begin n_done++; if (i < 64) done_bits[i] = 1'b1; end
         if (bus.aborted) n_abort++;
         if (i < 64) sh[i] = bus.shot_idx;
         if (!bus.busy) begin
            end_cyc = i;
            break;
         end
         bus.fifo_prog_full = (i < 64) ? pf_mask[i] : 1'b0;
         bus.acq_start      = (i < 64) ? st_mask[i] : 1'b0;
         @(negedge clk);
      end
      bus.fifo_prog_full = 1'b0;
      bus.acq_start = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      bus.ready_in = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if ({bus.tx_en, bus.fifo_wr_en, bus.busy, bus.acq_done, bus.aborted,
           bus.overflow, bus.shot_idx, bus.state_dbg} !== 24'd0) begin
         failures++;
         $display("FAIL reset_outputs got tx=%b wr=%b busy=%b st=%0d exp all 0",
                  bus.tx_en, bus.fifo_wr_en, bus.busy, bus.state_dbg);
      end
      reset = 1'b0;
   endtask

   task automatic test_single_shot();
      set_cfg(4, 2, 8, 0, 1);
      arm();
      capture('0, '0, 1'b0, 60);
      checks++;
      if (tx_bits !== 64'h1e) begin failures++; $display("FAIL t1_tx got=%h exp=%h", tx_bits, 64'h1e); end
      checks++;
      if (wr_bits !== 64'h7f80) begin failures++; $display("FAIL t1_wr got=%h exp=%h", wr_bits, 64'h7f80); end
      checks++;
      if (done_bits !== 64'h8000) begin failures++; $display("FAIL t1_done got=%h exp=%h", done_bits, 64'h8000); end
      checks++;
      if (end_cyc != 16) begin failures++; $display("FAIL t1_busy_end got=%0d exp=16", end_cyc); end
   endtask

   task automatic test_multi_shot();
      set_cfg(2, 0, 3, 5, 3);
      arm();
      capture('0, '0, 1'b1, 60);
      checks++;
      if (tx_bits !== 64'h0060_1806) begin failures++; $display("FAIL t2_tx got=%h exp=%h", tx_bits, 64'h0060_1806); end
      checks++;
      if (wr_bits !== 64'h0380_e038) begin failures++; $display("FAIL t2_wr got=%h exp=%h", wr_bits, 64'h0380_e038); end
      checks++;
      if (done_bits !== 64'h8000_0000 || n_done != 1) begin
         failures++; $display("FAIL t2_done got=%h n=%0d exp=%h n=1", done_bits, n_done, 64'h8000_0000);
      end
      checks++;
      if (n_wr != 9) begin failures++; $display("FAIL t2_writes got=%0d exp=9", n_wr); end
      checks++;
      if (sh[1] !== 16'd0 || sh[11] !== 16'd1 || sh[21] !== 16'd2) begin
         failures++; $display("FAIL t2_shot_idx got=%0d,%0d,%0d exp=0,1,2", sh[1], sh[11], sh[21]);
      end
      checks++;
      if (end_cyc != 32) begin failures++; $display("FAIL t2_busy_end got=%0d exp=32", end_cyc); end
   endtask

   task automatic test_overflow();
      set_cfg(1, 0, 10, 0, 1);
      arm();
      capture(64'h70, '0, 1'b0, 60);
      checks++;
      if (wr_bits !== 64'hf1c) begin failures++; $display("FAIL t3_wr got=%h exp=%h", wr_bits, 64'hf1c); end
      checks++;
      if (n_wr != 7) begin failures++; $display("FAIL t3_writes got=%0d exp=7", n_wr); end
      checks++;
      if (done_bits !== 64'h1000) begin failures++; $display("FAIL t3_done got=%h exp=%h", done_bits, 64'h1000); end
      checks++;
      if (bus.overflow !== 1'b1) begin failures++; $display("FAIL t3_overflow got=%b exp=1", bus.overflow); end
   endtask

   task automatic test_abort();
      set_cfg(4, 0, 5, 0, 1);
      arm();
      // start and abort together in ARMED: abort wins, nothing launches
      bus.acq_start = 1'b1; bus.acq_abort = 1'b1;
      @(negedge clk);
      bus.acq_start = 1'b0; bus.acq_abort = 1'b0;
      checks++;
      if (bus.state_dbg !== 3'd1 || bus.tx_en !== 1'b0 || bus.aborted !== 1'b0) begin
         failures++; $display("FAIL t4_start_abort st=%0d tx=%b ab=%b exp 1/0/0", bus.state_dbg, bus.tx_en, bus.aborted);
      end
      bus.acq_start = 1'b1;
      @(negedge clk);
      bus.acq_start = 1'b0;
      checks++;
      if (bus.tx_en !== 1'b1 || bus.overflow !== 1'b0) begin
         failures++; $display("FAIL t4_cycle1 tx=%b ovf=%b exp 1/0", bus.tx_en, bus.overflow);
      end
      @(negedge clk);
      bus.acq_abort = 1'b1;
      @(negedge clk);
      bus.acq_abort = 1'b0;
      checks++;
      if (bus.tx_en !== 1'b0 || bus.aborted !== 1'b1 || bus.acq_done !== 1'b0 || bus.state_dbg !== 3'd0) begin
         failures++; $display("FAIL t4_abort tx=%b ab=%b done=%b st=%0d exp 0/1/0/0",
                              bus.tx_en, bus.aborted, bus.acq_done, bus.state_dbg);
      end
      @(negedge clk);
      checks++;
      if (bus.aborted !== 1'b0 || bus.state_dbg !== 3'd1) begin
         failures++; $display("FAIL t4_rearm ab=%b st=%0d exp 0/1", bus.aborted, bus.state_dbg);
      end
   endtask

   task automatic test_zero_cfg();
      set_cfg(0, 0, 0, 0, 0);
      arm();
      capture('0, 64'h2, 1'b0, 20);
      checks++;
      if (tx_bits !== 64'h2 || wr_bits !== 64'h0) begin
         failures++; $display("FAIL t5_trace tx=%h wr=%h exp 2/0", tx_bits, wr_bits);
      end
      checks++;
      if (done_bits !== 64'h4 || end_cyc != 3) begin
         failures++; $display("FAIL t5_done got=%h end=%0d exp=4 end=3", done_bits, end_cyc);
      end
      // ready_in low keeps the sequencer out of ARMED and start does nothing
      bus.ready_in = 1'b0;
      repeat (3) @(negedge clk);
      bus.acq_start = 1'b1;
      @(negedge clk);
      bus.acq_start = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.state_dbg !== 3'd0 || bus.tx_en !== 1'b0 || bus.busy !== 1'b0) begin
         failures++; $display("FAIL t5_not_ready st=%0d tx=%b busy=%b exp 0/0/0", bus.state_dbg, bus.tx_en, bus.busy);
      end
      bus.ready_in = 1'b1;
      bus.fifo_prog_full = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (bus.state_dbg !== 3'd0) begin failures++; $display("FAIL t5_pf_block st=%0d exp=0", bus.state_dbg); end
      bus.fifo_prog_full = 1'b0;
   endtask

   task automatic test_reset_mid_rx();
      set_cfg(1, 0, 100, 0, 1);
      arm();
      bus.acq_start = 1'b1;
      @(negedge clk);
      bus.acq_start = 1'b0;
      repeat (47) @(negedge clk);
      checks++;
      if (bus.fifo_wr_en !== 1'b1) begin failures++; $display("FAIL t6_in_rx wr=%b exp=1", bus.fifo_wr_en); end
      bus.fifo_prog_full = 1'b1;
      @(negedge clk);
      checks++;
      if (bus.fifo_wr_en !== 1'b0 || bus.overflow !== 1'b1) begin
         failures++; $display("FAIL t6_pf wr=%b ovf=%b exp 0/1", bus.fifo_wr_en, bus.overflow);
      end
      bus.fifo_prog_full = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      checks++;
      if ({bus.tx_en, bus.fifo_wr_en, bus.busy, bus.acq_done, bus.aborted,
           bus.overflow, bus.shot_idx, bus.state_dbg} !== 24'd0) begin
         failures++; $display("FAIL t6_reset wr=%b busy=%b ovf=%b st=%0d exp all 0",
                              bus.fifo_wr_en, bus.busy, bus.overflow, bus.state_dbg);
      end
      reset = 1'b0;
      arm();
      capture('0, '0, 1'b0, 200);
      checks++;
      if (n_wr != 100 || n_done != 1) begin
         failures++; $display("FAIL t6_rerun writes=%0d done=%0d exp 100/1", n_wr, n_done);
      end
      checks++;
      if (end_cyc != 103) begin failures++; $display("FAIL t6_busy_end got=%0d exp=103", end_cyc); end
   endtask

   initial begin
      reset = 1'b1;
      bus.acq_start = 1'b0;
      bus.acq_abort = 1'b0;
      bus.ready_in = 1'b0;
      bus.fifo_prog_full = 1'b0;
      set_cfg(0, 0, 0, 0, 0);
      test_reset();
      test_single_shot();
      test_multi_shot();
      test_overflow();
      test_abort();
      test_zero_cfg();
      test_reset_mid_rx();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/acq_sequencer.md
Name: acq_sequencer

Overview:
- Single-clock acquisition sequencer in the `adc_data_clk` domain.
- Runs a triggered multi-shot burst: DAC transmit window (`tx_en`), programmable TX-to-RX delay, exact-length FIFO write window (`fifo_wr_en`), inter-shot gap, repeated `cfg_shots` times.
- Sits between okHost endpoints (wires/triggers already in `adc_data_clk`) and the DAC `tx_en` / ADC capture FIFO `wr_en`.
- Replaces the ad-hoc main controller FSM.

Parameters:
- CNT_W, 16, width of tx/delay/gap/shot counters and config fields
- RX_W, 32, width of RX sample count

Ports:
- adc_data_clk  in  1  sole clock
- reset  in  1  synchronous, active-high
- cfg_tx_cycles  in  CNT_W  TX window length in clocks (0 treated as 1)
- cfg_rx_delay  in  CNT_W  clocks between end of TX and start of RX (0 = none)
- cfg_rx_samples  in  RX_W  samples written per shot (0 = RX skipped)
- cfg_gap  in  CNT_W  idle clocks after each RX (0 = none)
- cfg_shots  in  CNT_W  shots per acquisition (0 treated as 1)
- acq_start  in  1  single-cycle start trigger
- acq_abort  in  1  single-cycle abort trigger
- ready_in  in  1  locked & adc_data_valid & ~fifo_busy
- fifo_prog_full  in  1  capture FIFO prog_full
- tx_en  out  1  DAC transmit enable
- fifo_wr_en  out  1  capture FIFO write enable
- busy  out  1  high in TX/DELAY/RX/GAP/DONE
- acq_done  out  1  one-cycle pulse on normal completion
- aborted  out  1  one-cycle pulse on abort
- overflow  out  1  sticky: prog_full seen during RX; cleared on next accepted acq_start or reset
- shot_idx  out  CNT_W  index of current shot, 0-based
- state_dbg  out  3  encoded state for debug pins

Behaviour:
- All outputs are registered. Reset value of every output is 0; state returns to IDLE.
- States and transitions:
  - IDLE: → ARMED when ready_in & ~fifo_prog_full.
  - ARMED: → IDLE if ready_in drops. On acq_start: latch all cfg_* into shadow registers, clear overflow, shot_idx ← 0, → TX.
  - TX: tx_en = 1 for exactly max(cfg_tx_cycles, 1) clocks. Then → DELAY if delay ≠ 0; else → RX if samples ≠ 0; else → GAP/next-shot decision.
  - DELAY: exactly cfg_rx_delay clocks, all outputs low. Then → RX, or skip RX if samples = 0.
  - RX: fifo_wr_en = ~fifo_prog_full for exactly cfg_rx_samples clocks.
    - The count is exact, not N+1.
    - The sample counter advances every clock regardless of prog_full, so shot timing is fixed.
    - Any cycle with prog_full sets overflow.
  - GAP: cfg_gap clocks. Then:
    - if shot_idx == shots−1 → DONE;
    - else shot_idx++ and → TX.
    - With gap = 0 the decision is taken in the last RX cycle, so TX begins on the next clock.
  - DONE: acq_done = 1 for one clock → IDLE.
- Latency: acq_start sampled in ARMED at cycle k gives tx_en = 1 from k+1. Phases are contiguous with no dead cycle between phases.
- acq_start outside ARMED is ignored, with no queueing.
- Config changes during a run are ignored; only the shadow registers are used.
- acq_abort in any state other than IDLE/ARMED:
  - next clock → IDLE;
  - tx_en and fifo_wr_en go low;
  - aborted pulses;
  - acq_done is not asserted.
- acq_abort and acq_start in the same ARMED cycle: abort wins; stay ARMED with no pulse.
- reset mid-operation: every output cleared next clock; state IDLE.
- All counters are down-counters loaded with length−1 and terminating at 0. There is no wrap-around; maximum values are 2^CNT_W−1 and 2^RX_W−1.

Decomposition:
- Package acq_seq_pkg:
  - state encoding: IDLE=0, ARMED=1, TX=2, DELAY=3, RX=4, GAP=5, DONE=6;
  - default widths CNT_W/RX_W;
  - state_dbg mapping.
- Sub-module acq_phase_counter: loadable down-counter with terminal flag, parameterised width. One instance is shared across TX/DELAY/GAP (CNT_W) and one is dedicated to RX (RX_W).

Test Plan:
- shots=1, tx=4, delay=2, rx=8, gap=0: start → tx_en high 4 clocks from k+1, 2 low, fifo_wr_en high exactly 8, acq_done at next clock, busy low after.
- shots=3, tx=2, delay=0, rx=3, gap=5: three identical 2/3/5 patterns, shot_idx 0,1,2, single acq_done; 9 total writes.
- rx=10, prog_full forced high in samples 4–6: fifo_wr_en low those 3 clocks, 7 writes, overflow sticky, shot length unchanged.
- acq_abort during 2nd TX clock: tx_en low next clock, aborted pulse, no acq_done, state IDLE → ARMED when ready.
- tx=0, delay=0, rx=0, gap=0, shots=0: one-cycle TX, no writes, acq_done; acq_start while busy ignored; ready_in low blocks arming.
- reset asserted mid-RX with rx=100: all outputs 0 next clock; a new run then completes with exactly 100 writes.
